// File: rtl/cva6_pma_table_if.sv
// cva6_pma_table_if: config port and lookup/result handshake bundle of the PMA table
interface cva6_pma_table_if #(
  parameter int unsigned AddrWidth = 64
);
  logic                 cfg_req;
  logic                 cfg_gnt;
  logic                 cfg_we;
  logic [3:0]           cfg_idx;
  logic [1:0]           cfg_field;
  logic [AddrWidth-1:0] cfg_wdata;
  logic                 cfg_rvalid;
  logic [AddrWidth-1:0] cfg_rdata;
  logic                 cfg_err;
  logic                 lookup_valid;
  logic                 lookup_ready;
  logic [AddrWidth-1:0] lookup_addr;
  logic                 result_valid;
  logic                 result_ready;
  logic                 result_hit;
  logic [3:0]           result_idx;
  logic                 result_cached;
  logic                 result_nonidem;
  logic                 result_exec;
  modport master (
    output cfg_req, cfg_we, cfg_idx, cfg_field, cfg_wdata, lookup_valid, lookup_addr, result_ready,
    input  cfg_gnt, cfg_rvalid, cfg_rdata, cfg_err, lookup_ready, result_valid, result_hit,
           result_idx, result_cached, result_nonidem, result_exec
  );
  modport slave (
    input  cfg_req, cfg_we, cfg_idx, cfg_field, cfg_wdata, lookup_valid, lookup_addr, result_ready,
    output cfg_gnt, cfg_rvalid, cfg_rdata, cfg_err, lookup_ready, result_valid, result_hit,
           result_idx, result_cached, result_nonidem, result_exec
  );
endinterface

// File: rtl/cva6_pma_table.sv
// cva6_pma_table: runtime-programmable physical memory attribute table with registered lookups
module cva6_pma_table #(
  parameter int unsigned                   NrRules     = 8,
  parameter int unsigned                   AddrWidth   = 64,
  parameter logic [NrRules*AddrWidth-1:0]  RstBase     = '0,
  parameter logic [NrRules*AddrWidth-1:0]  RstLength   = '0,
  parameter logic [NrRules*4-1:0]          RstAttr     = '0,
  parameter logic [2:0]                    DefaultAttr = 3'b000
) (
  input  logic              clk,
  input  logic              rst,
  cva6_pma_table_if.slave   bus
);
  logic [AddrWidth-1:0] base_q [NrRules];
  logic [AddrWidth-1:0] len_q  [NrRules];
  logic [3:0]           attr_q [NrRules];
  logic [AddrWidth-1:0] sel_base, sel_len, rdata;
  logic [3:0]           sel_attr;
  logic                 err, wr, hit;
  logic [3:0]           idx;
  logic [2:0]           attr;
  assign bus.cfg_gnt      = 1'b1;
  assign bus.lookup_ready = !bus.result_valid | bus.result_ready;
  // decode the config access: addressed rule, error cases and read data
  always_comb begin
    sel_base = '0;
    sel_len  = '0;
    sel_attr = '0;
    for (int i = 0; i < NrRules; i++)
      if (bus.cfg_idx == 4'(i)) begin
        sel_base = base_q[i];
        sel_len  = len_q[i];
        sel_attr = attr_q[i];
      end
    err   = 32'(bus.cfg_idx) >= NrRules || bus.cfg_field == 2'd3 || (bus.cfg_we && sel_attr[3]);
    wr    = bus.cfg_req && bus.cfg_we && !err;
    rdata = (err || bus.cfg_we) ? '0 :
            bus.cfg_field == 2'd0 ? sel_base :
            bus.cfg_field == 2'd1 ? sel_len : {{(AddrWidth-4){1'b0}}, sel_attr};
  end
  // priority match: scanning downwards lets the lowest matching index win
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    attr = DefaultAttr;
    for (int i = int'(NrRules) - 1; i >= 0; i--)
      if (len_q[i] != '0 && bus.lookup_addr >= base_q[i] && (bus.lookup_addr - base_q[i]) < len_q[i]) begin
        hit  = 1'b1;
        idx  = 4'(i);
        attr = attr_q[i][2:0];
      end
  end
  // table registers; a locked rule never reaches wr, so lock is sticky until reset
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int i = 0; i < NrRules; i++) begin
        base_q[i] <= RstBase[i*AddrWidth +: AddrWidth];
        len_q[i]  <= RstLength[i*AddrWidth +: AddrWidth];
        attr_q[i] <= RstAttr[i*4 +: 4];
      end
    else if (wr)
      for (int i = 0; i < NrRules; i++)
        if (bus.cfg_idx == 4'(i)) begin
          if (bus.cfg_field == 2'd0) base_q[i] <= bus.cfg_wdata;
          else if (bus.cfg_field == 2'd1) len_q[i] <= bus.cfg_wdata;
          else attr_q[i] <= bus.cfg_wdata[3:0];
        end
  // one-cycle config response
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.cfg_rvalid <= 1'b0;
      bus.cfg_err    <= 1'b0;
      bus.cfg_rdata  <= '0;
    end else begin
      bus.cfg_rvalid <= bus.cfg_req;
      bus.cfg_err    <= bus.cfg_req && err;
      bus.cfg_rdata  <= bus.cfg_req ? rdata : '0;
    end
  // single output stage: load on accept, hold while stalled, drain when consumed
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.result_valid   <= 1'b0;
      bus.result_hit     <= 1'b0;
      bus.result_idx     <= '0;
      bus.result_exec    <= 1'b0;
      bus.result_nonidem <= 1'b0;
      bus.result_cached  <= 1'b0;
    end else if (bus.lookup_valid && bus.lookup_ready) begin
      bus.result_valid   <= 1'b1;
      bus.result_hit     <= hit;
      bus.result_idx     <= idx;
      bus.result_exec    <= attr[2];
      bus.result_nonidem <= attr[1];
      bus.result_cached  <= attr[0];
    end else if (bus.result_ready)
      bus.result_valid <= 1'b0;
endmodule

// File: tb/tb_cva6_pma_table.sv
// tb_cva6_pma_table: scoreboard bench for the PMA table lookup and config paths
module tb_cva6_pma_table;
  localparam int NR = 3;
  localparam logic [NR*64-1:0] RB = {64'h8000_0000, 64'h1_0000, 64'h0};
  localparam logic [NR*64-1:0] RL = {64'h4000_0000, 64'h1_0000, 64'h1000};
  localparam logic [NR*4-1:0]  RA = {4'h5, 4'h4, 4'h4};
  localparam logic [2:0]       DA = 3'b010;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int n_acc = 0;
  logic [63:0] mb [16];
  logic [63:0] ml [16];
  logic [3:0]  ma [16];
  logic [7:0]  rq [$];
  logic [64:0] cq [$];
  logic        e;
  logic [63:0] r;
  cva6_pma_table_if #(.AddrWidth(64)) b();
  cva6_pma_table #(
    .NrRules(NR), .AddrWidth(64), .RstBase(RB), .RstLength(RL), .RstAttr(RA), .DefaultAttr(DA)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(b.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] res_obs();
    return {b.result_hit, b.result_idx, b.result_exec, b.result_nonidem, b.result_cached};
  endfunction
  function automatic logic [7:0] predict(input logic [63:0] a);
    logic [7:0] p = {5'b0, DA};
    for (int i = NR - 1; i >= 0; i--)
      if (ml[i] != 0 && a >= mb[i] && {1'b0, a} < {1'b0, mb[i]} + {1'b0, ml[i]})
        p = {1'b1, 4'(i), ma[i][2:0]};
    return p;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mb[i] = i < NR ? RB[i*64 +: 64] : 64'h0;
      ml[i] = i < NR ? RL[i*64 +: 64] : 64'h0;
      ma[i] = i < NR ? RA[i*4 +: 4] : 4'h0;
    end
    rq.delete();
    cq.delete();
  endtask
  task automatic model_cfg();
    int i = int'(b.cfg_idx);
    logic er = i >= NR || b.cfg_field == 2'd3 || (b.cfg_we && ma[i][3]);
    logic [63:0] rd = 64'h0;
    if (!er && !b.cfg_we)
      rd = b.cfg_field == 2'd0 ? mb[i] : b.cfg_field == 2'd1 ? ml[i] : {60'h0, ma[i]};
    cq.push_back({er, rd});
    if (!er && b.cfg_we) begin
      if (b.cfg_field == 2'd0) mb[i] = b.cfg_wdata;
      else if (b.cfg_field == 2'd1) ml[i] = b.cfg_wdata;
      else ma[i] = b.cfg_wdata[3:0];
    end
  endtask
  always @(negedge clk)
    if (!rst) begin
      chk("cfg_rvalid", {64'h0, b.cfg_rvalid}, {64'h0, cq.size() != 0});
      if (b.cfg_rvalid && cq.size() != 0) chk("cfg_resp", {b.cfg_err, b.cfg_rdata}, cq.pop_front());
      chk("res_valid", {64'h0, b.result_valid}, {64'h0, rq.size() != 0});
      if (b.result_valid && rq.size() != 0) begin
        chk("res", {57'h0, res_obs()}, {57'h0, rq[0]});
        if (b.result_ready) void'(rq.pop_front());
      end
      if (b.lookup_valid && b.lookup_ready) begin
        rq.push_back(predict(b.lookup_addr));
        n_acc++;
      end
      if (b.cfg_req) model_cfg();
    end
  task automatic look(input logic [63:0] a);
    @(posedge clk) #1;
    b.lookup_valid = 1'b1;
    b.lookup_addr  = a;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (b.lookup_ready) break;
      if (n > 50) begin
        chk("look_timeout", 65'h0, 65'h1);
        break;
      end
    end
    @(posedge clk) #1;
    b.lookup_valid = 1'b0;
  endtask
  task automatic look_exp(input string tag, input logic [63:0] a, input logic [7:0] x);
    look(a);
    @(negedge clk);
    chk(tag, {57'h0, res_obs()}, {57'h0, x});
  endtask
  task automatic cfg(input logic we, input logic [3:0] idx, input logic [1:0] f, input logic [63:0] wd,
                     output logic er, output logic [63:0] rd);
    @(posedge clk) #1;
    b.cfg_req = 1'b1;
    b.cfg_we = we;
    b.cfg_idx = idx;
    b.cfg_field = f;
    b.cfg_wdata = wd;
    @(posedge clk) #1;
    b.cfg_req = 1'b0;
    @(negedge clk);
    er = b.cfg_err;
    rd = b.cfg_rdata;
  endtask
  task automatic do_reset();
    @(posedge clk) #1;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("rst_outs", {58'h0, b.cfg_gnt, b.lookup_ready, b.cfg_rvalid, b.cfg_err, b.result_valid, b.result_hit, b.cfg_rdata == 0},
        {58'h0, 7'b1100001});
    @(posedge clk) #1;
    rst = 1'b0;
  endtask
  initial begin
    b.cfg_req = 0; b.cfg_we = 0; b.cfg_idx = 0; b.cfg_field = 0; b.cfg_wdata = 0;
    b.lookup_valid = 0; b.lookup_addr = 0; b.result_ready = 1;
    model_reset();
    do_reset();
    look_exp("rst_hit_r2", 64'h8000_1000, 8'h95);
    look_exp("rst_miss", 64'h2000, 8'h02);
    look_exp("bnd_fff", 64'hFFF, 8'h84);
    look_exp("bnd_1000", 64'h1000, 8'h02);
    cfg(1, 1, 0, 64'hFFFF_FFFF_FFFF_F000, e, r);
    chk("wr_base_err", {64'h0, e}, 65'h0);
    cfg(1, 1, 1, 64'h2000, e, r);
    look_exp("top_nowrap", 64'hFFFF_FFFF_FFFF_FFFF, 8'h8C);
    look_exp("zero_idx0", 64'h0, 8'h84);
    cfg(1, 1, 0, 64'h400, e, r);
    cfg(1, 1, 1, 64'h200, e, r);
    look_exp("ovl_prio", 64'h500, 8'h84);
    cfg(1, 0, 1, 64'h0, e, r);
    look_exp("ovl_len0", 64'h500, 8'h8C);
    cfg(1, 0, 2, 64'h9, e, r);
    chk("lock_set_err", {64'h0, e}, 65'h0);
    cfg(1, 0, 0, 64'h100, e, r);
    chk("lock_wr_err", {64'h0, e}, 65'h1);
    cfg(0, 0, 0, 64'h0, e, r);
    chk("lock_rd", {e, r}, 65'h0);
    cfg(0, 0, 2, 64'h0, e, r);
    chk("lock_attr_rd", {e, r}, 65'h9);
    do_reset();
    cfg(1, 0, 0, 64'h100, e, r);
    chk("unlock_wr_err", {64'h0, e}, 65'h0);
    cfg(0, 0, 0, 64'h0, e, r);
    chk("unlock_rd", {e, r}, 65'h100);
    @(posedge clk) #1;
    b.result_ready = 1'b0;
    b.lookup_valid = 1'b1;
    b.lookup_addr = 64'h8000_1000;
    @(posedge clk) #1;
    b.lookup_addr = 64'hFFF;
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready", {64'h0, b.lookup_ready}, 65'h0);
      chk("bp_hold", {57'h0, b.result_valid, res_obs()}, {57'h1, 8'h95});
    end
    @(posedge clk) #1;
    b.result_ready = 1'b1;
    @(posedge clk) #1;
    b.lookup_valid = 1'b0;
    @(negedge clk);
    chk("bp_next", {57'h0, res_obs()}, {57'h0, 8'h84});
    begin
      int start = n_acc;
      for (int c = 0; c < 3000 && n_acc < start + 100; c++) begin
        @(posedge clk) #1;
        b.lookup_valid = 1'($urandom);
        b.result_ready = $urandom_range(0, 3) != 0;
        case ($urandom_range(0, 3))
          0: b.lookup_addr = 64'h8000_0000 + 64'($urandom_range(0, 4)) - 64'h2;
          1: b.lookup_addr = 64'h1_0000 + 64'($urandom);
          2: b.lookup_addr = {$urandom, $urandom};
          default: b.lookup_addr = 64'hFE + 64'($urandom_range(0, 4100));
        endcase
      end
      @(posedge clk) #1;
      b.lookup_valid = 1'b0;
      b.result_ready = 1'b1;
      repeat (3) @(posedge clk);
      chk("rand_count", {64'h0, n_acc >= start + 100}, 65'h1);
    end
    @(posedge clk) #1;
    b.cfg_req = 1'b1; b.cfg_we = 1'b1; b.cfg_idx = 4'd2; b.cfg_field = 2'd1; b.cfg_wdata = 64'h0;
    b.lookup_valid = 1'b1; b.lookup_addr = 64'h8000_0000;
    @(posedge clk) #1;
    b.cfg_req = 1'b0;
    b.lookup_valid = 1'b0;
    @(negedge clk);
    chk("same_cyc_res", {57'h0, res_obs()}, {57'h0, 8'h95});
    chk("same_cyc_err", {64'h0, b.cfg_err}, 65'h0);
    look_exp("after_wr_miss", 64'h8000_0000, 8'h02);
    cfg(0, 12, 0, 64'h0, e, r);
    chk("idx12", {e, r}, {1'b1, 64'h0});
    cfg(0, 1, 3, 64'h0, e, r);
    chk("field3", {e, r}, {1'b1, 64'h0});
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("sb_res_empty", 65'(rq.size()), 65'h0);
    chk("sb_cfg_empty", 65'(cq.size()), 65'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
